// File: rtl/b_to_g_if.sv
// Bit-level bus for the binary-to-Gray converter.
// The source drives B3..B0 and in_valid; the converter returns G3..G0, out_valid and adj_ok.
interface b_to_g_if;
  logic B3;
  logic B2;
  logic B1;
  logic B0;
  logic in_valid;
  logic G3;
  logic G2;
  logic G1;
  logic G0;
  logic out_valid;
  logic adj_ok;

  modport master (
    output B3, B2, B1, B0, in_valid,
    input  G3, G2, G1, G0, out_valid, adj_ok
  );

  modport slave (
    input  B3, B2, B1, B0, in_valid,
    output G3, G2, G1, G0, out_valid, adj_ok
  );
endinterface

// File: rtl/b_to_g.sv
// 4-bit binary to reflected-binary Gray converter with one register stage.
// It also flags when each new valid code differs from the last valid code in exactly one bit.
module b_to_g (
  input  logic     clk,
  input  logic     rst,
  b_to_g_if.slave  bus
);

  function automatic logic [3:0] to_gray(input logic [3:0] bin);
    return bin ^ {1'b0, bin[3:1]};
  endfunction

  function automatic logic single_bit(input logic [3:0] diff);
    return (diff != 4'd0) && ((diff & (diff - 4'd1)) == 4'd0);
  endfunction

  logic [3:0] bin_p0;
  logic [3:0] gray_p0;
  logic       vld_p0;

  logic [3:0] gray_p1;
  logic       vld_p1;
  logic       adj_p1;
  logic       have_prev;

  // p0: combinational conversion of the sampled inputs
  assign bin_p0  = {bus.B3, bus.B2, bus.B1, bus.B0};
  assign gray_p0 = to_gray(bin_p0);
  assign vld_p0  = bus.in_valid;

  // p1: registered outputs; gray_p1 also serves as the previous valid code
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gray_p1   <= 4'd0;
      vld_p1    <= 1'b0;
      adj_p1    <= 1'b0;
      have_prev <= 1'b0;
    end else if (vld_p0) begin
      gray_p1   <= gray_p0;
      vld_p1    <= 1'b1;
      adj_p1    <= have_prev && single_bit(gray_p0 ^ gray_p1);
      have_prev <= 1'b1;
    end else begin
      vld_p1    <= 1'b0;
      adj_p1    <= 1'b0;
    end
  end

  assign bus.G3        = gray_p1[3];
  assign bus.G2        = gray_p1[2];
  assign bus.G1        = gray_p1[1];
  assign bus.G0        = gray_p1[0];
  assign bus.out_valid = vld_p1;
  assign bus.adj_ok    = adj_p1;

endmodule

// File: tb/tb_b_to_g.sv
// Directed-vector bench for b_to_g with hand-computed Gray codes and adjacency flags.
module tb_b_to_g;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  b_to_g_if bus ();

  b_to_g dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  localparam logic [3:0] GRAY_TBL [16] = '{
    4'b0000, 4'b0001, 4'b0011, 4'b0010,
    4'b0110, 4'b0111, 4'b0101, 4'b0100,
    4'b1100, 4'b1101, 4'b1111, 4'b1110,
    4'b1010, 4'b1011, 4'b1001, 4'b1000
  };

  logic [3:0] g;
  assign g = {bus.G3, bus.G2, bus.G1, bus.G0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic apply(input logic [3:0] b, input logic v);
    @(negedge clk);
    {bus.B3, bus.B2, bus.B1, bus.B0} = b;
    bus.in_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [3:0] eg,
                            input logic ev, input logic ea);
    check({tag, "_g"},   g, eg);
    check({tag, "_vld"}, {3'b000, bus.out_valid}, {3'b000, ev});
    check({tag, "_adj"}, {3'b000, bus.adj_ok},    {3'b000, ea});
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    {bus.B3, bus.B2, bus.B1, bus.B0} = 4'd0;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expect_out("reset", 4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    apply(4'd9, 1'b0);
    expect_out("idle", 4'b0000, 1'b0, 1'b0);

    // Exhaustive sweep, then wrap 15 -> 0
    for (int i = 0; i < 16; i++) begin
      apply(4'(i), 1'b1);
      expect_out($sformatf("sweep%0d", i), GRAY_TBL[i], 1'b1, (i != 0));
    end
    apply(4'd0, 1'b1);
    expect_out("wrap", 4'b0000, 1'b1, 1'b1);

    apply(4'd3, 1'b1);
    expect_out("nonadj3", 4'b0010, 1'b1, 1'b1);
    apply(4'd5, 1'b1);
    expect_out("nonadj5", 4'b0111, 1'b1, 1'b0);

    apply(4'd6, 1'b1);
    expect_out("hold_load", 4'b0101, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      apply(4'd9, 1'b0);
      expect_out($sformatf("hold%0d", k), 4'b0101, 1'b0, 1'b0);
    end

    apply(4'd7, 1'b1);
    expect_out("rep_first", 4'b0100, 1'b1, 1'b1);
    apply(4'd7, 1'b1);
    expect_out("rep_second", 4'b0100, 1'b1, 1'b0);

    // Asynchronous reset mid-cycle while G is nonzero
    #2;
    rst = 1'b1;
    #1;
    expect_out("async_rst", 4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    apply(4'd12, 1'b1);
    expect_out("post_rst_first", 4'b1010, 1'b1, 1'b0);
    apply(4'd13, 1'b1);
    expect_out("post_rst_next", 4'b1011, 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
